// File: rtl/insn_byte_serializer_pkg.sv
// Shared definitions for the instruction byte serializer: class indices, opcode bytes,
// immediate lengths, FSM encoding and the per-class format record.
package insn_byte_serializer_pkg;

  localparam int IDX_80  = 0;
  localparam int IDX_81  = 1;
  localparam int IDX_82  = 2;
  localparam int IDX_83  = 3;
  localparam int IDX_87  = 4;
  localparam int IDX_B0  = 5;
  localparam int IDX_C0  = 6;
  localparam int IDX_C1  = 7;
  localparam int IDX_D0  = 8;
  localparam int IDX_D1  = 9;
  localparam int IDX_D2  = 10;
  localparam int IDX_D3  = 11;
  localparam int IDX_FD  = 12;
  localparam int IDX_FE  = 13;
  localparam int IDX_FF  = 14;
  localparam int IDX_NUM = 15;

  localparam logic [7:0] OPC_80 = 8'h80;
  localparam logic [7:0] OPC_81 = 8'h81;
  localparam logic [7:0] OPC_82 = 8'h82;
  localparam logic [7:0] OPC_83 = 8'h83;
  localparam logic [7:0] OPC_87 = 8'h87;
  localparam logic [7:0] OPC_B0 = 8'hB0;
  localparam logic [7:0] OPC_C0 = 8'hC0;
  localparam logic [7:0] OPC_C1 = 8'hC1;
  localparam logic [7:0] OPC_D0 = 8'hD0;
  localparam logic [7:0] OPC_D1 = 8'hD1;
  localparam logic [7:0] OPC_D2 = 8'hD2;
  localparam logic [7:0] OPC_D3 = 8'hD3;
  localparam logic [7:0] OPC_FD = 8'hFD;
  localparam logic [7:0] OPC_FE = 8'hFE;
  localparam logic [7:0] OPC_FF = 8'hFF;

  localparam logic [7:0] PFX_OPSIZE = 8'h66;

  localparam logic [2:0] IMM_NONE  = 3'd0;
  localparam logic [2:0] IMM_BYTE  = 3'd1;
  localparam logic [2:0] IMM_WORD  = 3'd2;
  localparam logic [2:0] IMM_DWORD = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PFX,
    ST_OPC,
    ST_MODRM,
    ST_IMM
  } state_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic       has_modrm;
    logic [2:0] imm_len;
    logic       wcap;
    logic       illegal;
  } insn_fmt_t;

endpackage

// File: rtl/insn_byte_serializer_fmt_lut.sv
// Combinational class-index to instruction-format table; the exact inverse of the decode
// hash for indices 0..14, anything above flagged illegal.
import insn_byte_serializer_pkg::*;

module insn_fmt_lut #(
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             op16,
  output insn_fmt_t        fmt
);

  always_comb begin
    fmt           = '0;
    fmt.has_modrm = 1'b1;
    fmt.imm_len   = IMM_NONE;
    case (32'(idx))
      IDX_80: begin fmt.opcode = OPC_80; fmt.imm_len = IMM_BYTE; end
      IDX_81: begin
        fmt.opcode  = OPC_81;
        fmt.imm_len = op16 ? IMM_WORD : IMM_DWORD;
        fmt.wcap    = 1'b1;
      end
      IDX_82: begin fmt.opcode = OPC_82; fmt.imm_len = IMM_BYTE; end
      IDX_83: begin fmt.opcode = OPC_83; fmt.imm_len = IMM_BYTE; fmt.wcap = 1'b1; end
      IDX_87: begin fmt.opcode = OPC_87; fmt.wcap = 1'b1; end
      IDX_B0: begin fmt.opcode = OPC_B0; fmt.imm_len = IMM_BYTE; fmt.has_modrm = 1'b0; end
      IDX_C0: begin fmt.opcode = OPC_C0; fmt.imm_len = IMM_BYTE; end
      IDX_C1: begin fmt.opcode = OPC_C1; fmt.imm_len = IMM_BYTE; fmt.wcap = 1'b1; end
      IDX_D0: fmt.opcode = OPC_D0;
      IDX_D1: begin fmt.opcode = OPC_D1; fmt.wcap = 1'b1; end
      IDX_D2: fmt.opcode = OPC_D2;
      IDX_D3: begin fmt.opcode = OPC_D3; fmt.wcap = 1'b1; end
      IDX_FD: begin fmt.opcode = OPC_FD; fmt.has_modrm = 1'b0; end
      IDX_FE: fmt.opcode = OPC_FE;
      IDX_FF: begin fmt.opcode = OPC_FF; fmt.wcap = 1'b1; end
      default: begin
        fmt.illegal   = 1'b1;
        fmt.has_modrm = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/insn_byte_serializer.sv
// Turns a class index plus operands into a legal x86 byte stream (0x66, opcode, ModRM,
// little-endian immediate), one byte per output handshake.
import insn_byte_serializer_pkg::*;

module insn_byte_serializer #(
  parameter bit PREFIX_EN = 1'b1,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [7:0]       in_modrm,
  input  logic [31:0]      in_imm,
  input  logic             in_op16,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             out_err
);

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [7:0]  opcode_q, modrm_q;
  logic        has_modrm_q;
  logic [2:0]  imm_len_q;
  logic [31:0] imm_q;

  insn_fmt_t   lut_fmt;
  logic        accept, hs, req_bad;
  logic [7:0]  opc_src, modrm_src;
  logic        has_modrm_src;
  logic [2:0]  len_src;
  logic [31:0] imm_src;
  logic [7:0]  byte_nxt;
  logic        last_nxt;

  insn_fmt_lut #(.IDX_W(IDX_W)) u_lut (
    .idx  (in_idx),
    .op16 (in_op16),
    .fmt  (lut_fmt)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state != ST_IDLE);
  assign accept    = in_valid & in_ready;
  assign hs        = out_valid & out_ready;
  assign req_bad   = lut_fmt.illegal | (lut_fmt.has_modrm & (in_modrm[7:6] != 2'b11));

  // While idle the first byte is built straight from the request being accepted.
  assign opc_src       = in_ready ? lut_fmt.opcode    : opcode_q;
  assign modrm_src     = in_ready ? in_modrm          : modrm_q;
  assign has_modrm_src = in_ready ? lut_fmt.has_modrm : has_modrm_q;
  assign len_src       = in_ready ? lut_fmt.imm_len   : imm_len_q;
  assign imm_src       = in_ready ? in_imm            : imm_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept && !req_bad)
          state_nxt = (PREFIX_EN && in_op16 && lut_fmt.wcap) ? ST_PFX : ST_OPC;
      end
      ST_PFX: begin
        if (hs) state_nxt = ST_OPC;
      end
      ST_OPC: begin
        if (hs) begin
          cnt_nxt = 2'd0;
          if (has_modrm_src)          state_nxt = ST_MODRM;
          else if (len_src != IMM_NONE) state_nxt = ST_IMM;
          else                        state_nxt = ST_IDLE;
        end
      end
      ST_MODRM: begin
        if (hs) begin
          cnt_nxt   = 2'd0;
          state_nxt = (len_src != IMM_NONE) ? ST_IMM : ST_IDLE;
        end
      end
      ST_IMM: begin
        if (hs) begin
          if ({1'b0, cnt} == len_src - 3'd1) state_nxt = ST_IDLE;
          else                               cnt_nxt   = cnt + 2'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The output stage is reloaded every cycle from the upcoming state, so a stalled byte
  // simply recomputes to the same value.
  always_comb begin
    byte_nxt = 8'h00;
    last_nxt = 1'b0;
    case (state_nxt)
      ST_PFX:   byte_nxt = PFX_OPSIZE;
      ST_OPC: begin
        byte_nxt = opc_src;
        last_nxt = !has_modrm_src && (len_src == IMM_NONE);
      end
      ST_MODRM: begin
        byte_nxt = modrm_src;
        last_nxt = (len_src == IMM_NONE);
      end
      ST_IMM: begin
        byte_nxt = imm_src[{cnt_nxt, 3'b000} +: 8];
        last_nxt = ({1'b0, cnt_nxt} == len_src - 3'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 2'd0;
      out_byte <= 8'h00;
      out_last <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      out_byte <= byte_nxt;
      out_last <= last_nxt;
      out_err  <= accept & req_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q    <= 8'h00;
      modrm_q     <= 8'h00;
      has_modrm_q <= 1'b0;
      imm_len_q   <= IMM_NONE;
      imm_q       <= 32'h0;
    end else if (accept && !req_bad) begin
      opcode_q    <= lut_fmt.opcode;
      modrm_q     <= in_modrm;
      has_modrm_q <= lut_fmt.has_modrm;
      imm_len_q   <= lut_fmt.imm_len;
      imm_q       <= in_imm;
    end
  end

endmodule

// File: tb/tb_insn_byte_serializer.sv
// Randomized self-checking bench: each request is compared against a table-driven model of
// the x86 encoding rules, with random sink backpressure and a mid-instruction reset.
module tb_insn_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_idx;
  logic [7:0]  in_modrm;
  logic [31:0] in_imm;
  logic        in_op16;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        out_err;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] exp_q[$];
  bit         exp_err;
  logic [7:0] opc_tab [15] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h87, 8'hB0, 8'hC0, 8'hC1,
                               8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hFD, 8'hFE, 8'hFF};

  insn_byte_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_modrm  (in_modrm),
    .in_imm    (in_imm),
    .in_op16   (in_op16),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Encoding rules written out directly as a byte list.
  function automatic void buildExpected(input logic [4:0] idx, input logic op16,
                                        input logic [7:0] modrm, input logic [31:0] imm);
    int len;
    bit has_modrm, wcap;
    exp_q.delete();
    has_modrm = !(idx == 5 || idx == 12);
    exp_err   = (idx >= 15) || (has_modrm && modrm[7:6] != 2'b11);
    if (exp_err) return;
    wcap = idx inside {1, 3, 4, 7, 9, 11, 14};
    if (idx inside {0, 2, 3, 5, 6, 7}) len = 1;
    else if (idx == 1)                 len = op16 ? 2 : 4;
    else                               len = 0;
    if (op16 && wcap) exp_q.push_back(8'h66);
    exp_q.push_back(opc_tab[idx]);
    if (has_modrm) exp_q.push_back(modrm);
    for (int i = 0; i < len; i++) exp_q.push_back(8'(imm >> (8 * i)));
  endfunction

  task automatic applyStimulus(input logic [4:0] idx, input logic [7:0] modrm,
                               input logic [31:0] imm, input logic op16, input int ready_pct);
    int         k;
    bit         done, stalled;
    logic [7:0] held_b;
    logic       held_l;
    buildExpected(idx, op16, modrm, imm);
    @(negedge clk);
    checkOutput("idle_in_ready", 32'(in_ready), 1);
    in_valid  = 1'b1;
    in_idx    = idx;
    in_modrm  = modrm;
    in_imm    = imm;
    in_op16   = op16;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    in_idx   = 5'($urandom);
    in_modrm = 8'($urandom);
    in_imm   = $urandom;
    in_op16  = 1'($urandom);
    if (exp_err) begin
      checkOutput("err_pulse", 32'(out_err), 1);
      checkOutput("err_no_valid", 32'(out_valid), 0);
      checkOutput("err_in_ready", 32'(in_ready), 1);
      @(negedge clk);
      checkOutput("err_clear", 32'(out_err), 0);
      checkOutput("err_no_valid2", 32'(out_valid), 0);
      return;
    end
    checkOutput("no_err", 32'(out_err), 0);
    k = 0; done = 0; stalled = 0; held_b = 8'h00; held_l = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (!out_valid) begin
        checkOutput($sformatf("valid_byte%0d", k), 32'(out_valid), 1);
        done = 1;
      end else begin
        checkOutput("busy_in_ready", 32'(in_ready), 0);
        if (stalled) begin
          checkOutput("hold_byte", 32'(out_byte), 32'(held_b));
          checkOutput("hold_last", 32'(out_last), 32'(held_l));
        end
        out_ready = ($urandom_range(99) < ready_pct);
        if (out_ready) begin
          checkOutput($sformatf("byte%0d", k), 32'(out_byte), 32'(exp_q[k]));
          checkOutput($sformatf("last%0d", k), 32'(out_last), 32'(k == exp_q.size() - 1));
          k++;
          stalled = 0;
          if (k == exp_q.size()) done = 1;
        end else begin
          stalled = 1;
          held_b  = out_byte;
          held_l  = out_last;
        end
      end
    end
    if (!done) checkOutput("timeout", 0, 1);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("after_no_valid", 32'(out_valid), 0);
    checkOutput("after_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    logic [7:0] rm;
    rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; in_modrm = '0; in_imm = '0;
    in_op16 = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_byte", 32'(out_byte), 0);
    checkOutput("rst_out_last", 32'(out_last), 0);
    checkOutput("rst_out_err", 32'(out_err), 0);
    rst_n = 1'b1;

    applyStimulus(5'd5, 8'h00, 32'h12, 1'b0, 100);
    applyStimulus(5'd1, 8'hC3, 32'h1234, 1'b1, 100);
    applyStimulus(5'd1, 8'hC0, 32'hDEADBEEF, 1'b0, 50);
    applyStimulus(5'd12, 8'h00, 32'h0, 1'b0, 100);
    applyStimulus(5'd9, 8'hE0, 32'h0, 1'b1, 100);
    applyStimulus(5'd15, 8'hC0, 32'h0, 1'b0, 100);
    applyStimulus(5'd8, 8'h05, 32'h0, 1'b0, 100);

    // Reset while the second immediate byte of 81 C0 EF BE AD DE is on the output.
    @(negedge clk);
    in_valid = 1'b1; in_idx = 5'd1; in_modrm = 8'hC0; in_imm = 32'hDEADBEEF; in_op16 = 1'b0;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_byte", 32'(out_byte), 32'hBE);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 1);
    checkOutput("mid_rst_out_byte", 32'(out_byte), 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    applyStimulus(5'd5, 8'h00, 32'h12, 1'b0, 100);

    for (int t = 0; t < 60; t++) begin
      rm = 8'($urandom);
      if ($urandom_range(0, 3) != 0) rm[7:6] = 2'b11;
      applyStimulus(5'($urandom_range(0, 16)), rm, $urandom, 1'($urandom),
                    ($urandom_range(0, 2) == 0) ? 100 : 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
